// File: rtl/product_word_serializer.sv
// product_word_serializer
// Captures one wide product per input handshake and streams it out as
// WORD_WIDTH words, least-significant word first, with valid/ready flow
// control and a last-word marker.
//
// Optional feature macro: PRODUCT_CHECKSUM_EN
//   When defined, one extra word (XOR of all data words) follows the final
//   data word and carries out_last instead.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | nothing held; in_ready=1, out_valid=0
// SEND  | presenting data word idx_q of the held product
// CSUM  | presenting the checksum word (PRODUCT_CHECKSUM_EN only)

module product_word_serializer #(
    parameter  int IN_WIDTH   = 512,
    parameter  int WORD_WIDTH = 32,
    localparam int NUM_WORDS  = IN_WIDTH / WORD_WIDTH,
    localparam int IDX_WIDTH  = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [IN_WIDTH-1:0]   in_product,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [WORD_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic [IDX_WIDTH-1:0]  out_index,
    output logic                  busy
);

    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_WORDS - 1);

`ifdef PRODUCT_CHECKSUM_EN
    typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, CSUM = 2'd2} state_t;
`else
    typedef enum logic [0:0] {IDLE = 1'b0, SEND = 1'b1} state_t;
`endif

    state_t                                state_q, state_d;
    logic [IDX_WIDTH-1:0]                  idx_q, idx_d;
    logic [NUM_WORDS-1:0][WORD_WIDTH-1:0]  held_q;
    logic                                  final_xfer;
    logic                                  accept;

`ifdef PRODUCT_CHECKSUM_EN
    logic [NUM_WORDS-1:0][WORD_WIDTH-1:0]  in_words;
    logic [WORD_WIDTH-1:0]                 csum_d, csum_q;

    assign in_words = in_product;

    // Checksum is formed from the incoming product so it is ready at capture.
    always_comb begin
        csum_d = '0;
        for (int i = 0; i < NUM_WORDS; i++) begin
            csum_d = csum_d ^ in_words[i];
        end
    end

    // Checksum register, loaded alongside the product.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csum_q <= '0;
        end else if (accept) begin
            csum_q <= csum_d;
        end
    end

    assign final_xfer = (state_q == CSUM) && out_ready;
`else
    assign final_xfer = (state_q == SEND) && (idx_q == LAST_IDX) && out_ready;
`endif

    // A new product can enter in IDLE or on the very cycle the last word leaves.
    assign in_ready = (state_q == IDLE) || final_xfer;
    assign accept   = in_valid && in_ready;
    assign busy     = (state_q != IDLE);

    // State and word index registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Product holding register; only an accepted handshake changes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            held_q <= '0;
        end else if (accept) begin
            held_q <= in_product;
        end
    end

    // Next-state, index advance and output word selection.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        out_valid = 1'b0;
        out_last  = 1'b0;
        out_index = '0;
        out_data  = '0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = SEND;
                    idx_d   = '0;
                end
            end
            SEND: begin
                out_valid = 1'b1;
                out_data  = held_q[idx_q];
                out_index = idx_q;
`ifdef PRODUCT_CHECKSUM_EN
                out_last  = 1'b0;
`else
                out_last  = (idx_q == LAST_IDX);
`endif
                if (out_ready) begin
                    if (idx_q != LAST_IDX) begin
                        idx_d = idx_q + 1'b1;
                    end else begin
`ifdef PRODUCT_CHECKSUM_EN
                        // Index stays saturated while the checksum is shown.
                        state_d = CSUM;
`else
                        idx_d   = '0;
                        state_d = accept ? SEND : IDLE;
`endif
                    end
                end
            end
`ifdef PRODUCT_CHECKSUM_EN
            CSUM: begin
                out_valid = 1'b1;
                out_data  = csum_q;
                out_index = LAST_IDX;
                out_last  = 1'b1;
                if (out_ready) begin
                    idx_d   = '0;
                    state_d = accept ? SEND : IDLE;
                end
            end
`endif
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_product_word_serializer.sv
// Directed bench for product_word_serializer: a vector table of products
// with flow-control patterns, plus hand-written back-to-back and
// mid-stream reset sequences. Honours PRODUCT_CHECKSUM_EN if defined.

module tb_product_word_serializer;

    localparam int IN_WIDTH   = 512;
    localparam int WORD_WIDTH = 32;
    localparam int NW         = IN_WIDTH / WORD_WIDTH;
`ifdef PRODUCT_CHECKSUM_EN
    localparam int TOTAL = NW + 1;
`else
    localparam int TOTAL = NW;
`endif

    logic                  clk;
    logic                  rst_n;
    logic [IN_WIDTH-1:0]   in_product;
    logic                  in_valid;
    logic                  in_ready;
    logic [WORD_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic                  out_last;
    logic [3:0]            out_index;
    logic                  busy;

    int passed = 0;
    int total  = 0;

    product_word_serializer #(
        .IN_WIDTH  (IN_WIDTH),
        .WORD_WIDTH(WORD_WIDTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_product(in_product),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .out_index (out_index),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [IN_WIDTH-1:0] product;
        logic [3:0]          pat;
        logic [31:0]         w0;
        logic [31:0]         w15;
        logic [31:0]         csum;
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            passed++;
        end
    endtask

    // Reference word n of a product; word NW is the XOR checksum.
    function automatic logic [31:0] exp_word(input logic [IN_WIDTH-1:0] p, input int n);
        logic [31:0] x;
        x = '0;
        if (n < NW) begin
            x = p[n*WORD_WIDTH +: WORD_WIDTH];
        end else begin
            for (int i = 0; i < NW; i++) x = x ^ p[i*WORD_WIDTH +: WORD_WIDTH];
        end
        return x;
    endfunction

    function automatic logic [3:0] exp_idx(input int n);
        return (n < NW) ? 4'(n) : 4'(NW - 1);
    endfunction

    // Sends one product from IDLE and follows every output cycle.
    task automatic run_vec(input vec_t v, input int vi);
        int n;
        int cyc;
        logic xfer;
        in_product = v.product;
        in_valid   = 1'b1;
        out_ready  = 1'b0;
        #1;
        check($sformatf("v%0d in_ready_idle", vi), 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid   = 1'b0;
        in_product = {16{$urandom()}};
        n   = 0;
        cyc = 0;
        while (n < TOTAL && cyc < 200) begin
            out_ready = v.pat[cyc % 4];
            #1;
            xfer = out_ready;
            check($sformatf("v%0d valid n%0d", vi, n), 64'(out_valid), 64'd1);
            check($sformatf("v%0d data n%0d", vi, n), 64'(out_data), 64'(exp_word(v.product, n)));
            check($sformatf("v%0d index n%0d", vi, n), 64'(out_index), 64'(exp_idx(n)));
            check($sformatf("v%0d last n%0d", vi, n), 64'(out_last), 64'(n == TOTAL - 1));
            check($sformatf("v%0d in_ready n%0d", vi, n), 64'(in_ready),
                  64'(xfer && (n == TOTAL - 1)));
            if (xfer) begin
                if (n == 0)  check($sformatf("v%0d hand_w0", vi),  64'(out_data), 64'(v.w0));
                if (n == 15) check($sformatf("v%0d hand_w15", vi), 64'(out_data), 64'(v.w15));
                if (n == NW) check($sformatf("v%0d hand_csum", vi), 64'(out_data), 64'(v.csum));
                n++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        if (n < TOTAL) check($sformatf("v%0d timeout", vi), 64'(n), 64'(TOTAL));
        out_ready = 1'b1;
        #1;
        check($sformatf("v%0d valid_after", vi), 64'(out_valid), 64'd0);
        check($sformatf("v%0d busy_after", vi), 64'(busy), 64'd0);
        check($sformatf("v%0d in_ready_after", vi), 64'(in_ready), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [IN_WIDTH-1:0] aw;
        logic [IN_WIDTH-1:0] p3;

        aw = '0;
        for (int i = 0; i < NW; i++) aw[i*WORD_WIDTH +: WORD_WIDTH] = 32'hA000_0000 + 32'(i);
        p3 = '0;
        p3[3*WORD_WIDTH +: WORD_WIDTH] = 32'h1234_5678;
        p3[9*WORD_WIDTH +: WORD_WIDTH] = 32'h0F0F_0F0F;

        vecs[0] = '{product: {{(IN_WIDTH-1){1'b0}}, 1'b1}, pat: 4'b1111,
                    w0: 32'h0000_0001, w15: 32'h0000_0000, csum: 32'h0000_0001};
        vecs[1] = '{product: aw, pat: 4'b0101,
                    w0: 32'hA000_0000, w15: 32'hA000_000F, csum: 32'h0000_0000};
        vecs[2] = '{product: {IN_WIDTH{1'b1}}, pat: 4'b1011,
                    w0: 32'hFFFF_FFFF, w15: 32'hFFFF_FFFF, csum: 32'h0000_0000};
        vecs[3] = '{product: p3, pat: 4'b0011,
                    w0: 32'h0000_0000, w15: 32'h0000_0000, csum: 32'h1D3B_5977};

        rst_n      = 1'b0;
        in_product = '0;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        #12;
        check("rst out_valid", 64'(out_valid), 64'd0);
        check("rst out_last",  64'(out_last),  64'd0);
        check("rst out_index", 64'(out_index), 64'd0);
        check("rst out_data",  64'(out_data),  64'd0);
        check("rst busy",      64'(busy),      64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst in_ready", 64'(in_ready), 64'd1);

        for (int v = 0; v < 4; v++) run_vec(vecs[v], v);

        // Back-to-back: in_valid held high, second product waits for the final transfer.
        out_ready  = 1'b1;
        in_product = {IN_WIDTH{1'b1}};
        in_valid   = 1'b1;
        @(posedge clk); #1;
        in_product = 512'h2;
        for (int k = 0; k < TOTAL; k++) begin
            #1;
            check($sformatf("b2b first data k%0d", k), 64'(out_data),
                  64'(exp_word({IN_WIDTH{1'b1}}, k)));
            check($sformatf("b2b in_ready k%0d", k), 64'(in_ready), 64'(k == TOTAL - 1));
            check($sformatf("b2b last k%0d", k), 64'(out_last), 64'(k == TOTAL - 1));
            @(posedge clk); #1;
            if (k == TOTAL - 1) in_valid = 1'b0;
        end
        for (int k = 0; k < TOTAL; k++) begin
            #1;
            check($sformatf("b2b second valid k%0d", k), 64'(out_valid), 64'd1);
            check($sformatf("b2b second data k%0d", k), 64'(out_data),
                  64'(exp_word(512'h2, k)));
            check($sformatf("b2b second index k%0d", k), 64'(out_index), 64'(exp_idx(k)));
            if (k == 0) check("b2b second w0 hand", 64'(out_data), 64'h2);
            @(posedge clk); #1;
        end
        #1;
        check("b2b busy_after", 64'(busy), 64'd0);
        check("b2b valid_after", 64'(out_valid), 64'd0);

        // Reset while word 7 is on the bus.
        in_product = vecs[1].product;
        in_valid   = 1'b1;
        out_ready  = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int k = 0; k < 7; k++) begin
            @(posedge clk); #1;
        end
        #1;
        check("midrst index before", 64'(out_index), 64'd7);
        check("midrst data before", 64'(out_data), 64'hA000_0007);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst out_valid", 64'(out_valid), 64'd0);
        check("midrst busy",      64'(busy),      64'd0);
        check("midrst out_data",  64'(out_data),  64'd0);
        check("midrst out_last",  64'(out_last),  64'd0);
        #3;
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check($sformatf("postrst valid c%0d", k), 64'(out_valid), 64'd0);
            check($sformatf("postrst busy c%0d", k), 64'(busy), 64'd0);
            check($sformatf("postrst in_ready c%0d", k), 64'(in_ready), 64'd1);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
